// File: rtl/cpu_pkg.sv
// Shared types and constants for the core's memory-side blocks.
package cpu_pkg;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_t;

    localparam int BYTE_LANES = 4;
    localparam logic [BYTE_LANES-1:0] WREN_LOAD = 4'b0000;
endpackage

// File: rtl/arb_fair_pick.sv
// Fetch vs load/store pick: load/store wins unless it has been granted
// MAX_DSTREAK times in a row while fetch was waiting.
module arb_fair_pick #(
    parameter int MAX_DSTREAK = 4
) (
    input  logic clk,
    input  logic rstd,
    input  logic halt,
    input  logic if_req,
    input  logic ls_req,
    output logic if_gnt,
    output logic ls_gnt
);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

    logic [3:0] r_streak;
    logic [3:0] w_streak_nxt;
    logic       w_if_turn;

    assign w_if_turn = (r_streak >= STREAK_MAX);

    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (!rstd && !halt) begin
            if (ls_req && !(if_req && w_if_turn)) begin
                ls_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    // Halt freezes the streak so arbitration resumes exactly where it stopped.
    always_comb begin
        w_streak_nxt = r_streak;
        if (!halt) begin
            if (ls_gnt && if_req) begin
                w_streak_nxt = w_if_turn ? STREAK_MAX : r_streak + 4'd1;
            end else begin
                w_streak_nxt = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            r_streak <= 4'd0;
        end else begin
            r_streak <= w_streak_nxt;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between fetch and load/store; read data returns
// one cycle after the grant, steered to the requester that owns it.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic                  clk,
    input  logic                  rstd,
    input  logic                  halt,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  ls_req,
    input  logic [BYTE_LANES-1:0] ls_wren,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic [DATA_W-1:0]     ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [DATA_W-1:0]     ls_rdata,
    output logic                  mem_en,
    output logic [BYTE_LANES-1:0] mem_wren,
    output logic [ADDR_W-3:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);
    owner_t r_pend_owner;
    owner_t w_own_nxt;
    logic   w_ls_read;
    logic   w_unused_lsb;

    arb_fair_pick #(
        .MAX_DSTREAK(MAX_DSTREAK)
    ) u_pick (
        .clk    (clk),
        .rstd   (rstd),
        .halt   (halt),
        .if_req (if_req),
        .ls_req (ls_req),
        .if_gnt (if_gnt),
        .ls_gnt (ls_gnt)
    );

    // Byte offsets are the requester's concern; the RAM is word addressed.
    assign w_unused_lsb = ^{if_addr[1:0], ls_addr[1:0]};

    assign w_ls_read = ls_gnt && (ls_wren == WREN_LOAD);

    always_comb begin
        mem_en    = if_gnt | ls_gnt;
        mem_wren  = WREN_LOAD;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ls_gnt) begin
            mem_wren  = ls_wren;
            mem_addr  = ls_addr[ADDR_W-1:2];
            mem_wdata = ls_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr[ADDR_W-1:2];
        end
    end

    always_comb begin
        w_own_nxt = OWN_NONE;
        if (if_gnt) begin
            w_own_nxt = OWN_IF;
        end else if (w_ls_read) begin
            w_own_nxt = OWN_LS;
        end
    end

    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            r_pend_owner <= OWN_NONE;
        end else begin
            r_pend_owner <= w_own_nxt;
        end
    end

    assign if_rvalid = (r_pend_owner == OWN_IF);
    assign ls_rvalid = (r_pend_owner == OWN_LS);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign ls_rdata  = ls_rvalid ? mem_rdata : '0;
endmodule
